// File: rtl/cost_packer_8.sv
// Serial-to-parallel packer: gathers 8 streamed costs into one packed group for argmin_8.
// Optional running-min outputs (min_value/min_index) are enabled with COST_PACKER_RUNNING_MIN_EN.
module cost_packer_8 #(
    parameter int WIDTH = 7,
    parameter int N     = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_cost,
    input  logic               in_last,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [N*WIDTH-1:0] out_data,
    output logic               sync_err
`ifdef COST_PACKER_RUNNING_MIN_EN
    ,
    output logic [WIDTH-1:0]   min_value,
    output logic [2:0]         min_index
`endif
);

    localparam logic [2:0] LAST_SLOT = 3'(N - 1);

    logic [2:0]         r_count;
    logic [WIDTH-1:0]   r_fill [N-1];
    logic               r_out_valid;
    logic [N*WIDTH-1:0] r_out_data;
    logic               r_sync_err;

    logic               w_accept;
    logic               w_complete;
    logic               w_drain;
    logic [N*WIDTH-1:0] w_group;

    assign w_drain    = r_out_valid && out_ready;
    // The completing beat needs the holding register free, or emptying on this same edge.
    assign in_ready   = (r_count != LAST_SLOT) || !r_out_valid || out_ready;
    assign w_accept   = in_valid && in_ready;
    assign w_complete = w_accept && (r_count == LAST_SLOT);

    always_comb begin
        w_group = '0;
        for (int k = 0; k < N - 1; k++) begin
            w_group[k*WIDTH +: WIDTH] = r_fill[k];
        end
        w_group[(N-1)*WIDTH +: WIDTH] = in_cost;
    end

    always_ff @(posedge clk) begin
        if (w_accept && (r_count != LAST_SLOT)) begin
            r_fill[r_count] <= in_cost;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count     <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_sync_err  <= 1'b0;
        end else begin
            if (w_accept) begin
                r_count <= r_count + 3'd1;
                if (in_last != (r_count == LAST_SLOT)) begin
                    r_sync_err <= 1'b1;
                end
            end
            if (w_complete) begin
                r_out_valid <= 1'b1;
                r_out_data  <= w_group;
            end else if (w_drain) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign sync_err  = r_sync_err;

`ifdef COST_PACKER_RUNNING_MIN_EN
    logic [WIDTH-1:0] r_run_min;
    logic [2:0]       r_run_idx;
    logic [WIDTH-1:0] r_min_value;
    logic [2:0]       r_min_index;
    logic             w_cand_lt;

    // Strict less-than keeps the earliest index on ties.
    assign w_cand_lt = in_cost < r_run_min;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_run_min   <= '1;
            r_run_idx   <= '0;
            r_min_value <= '0;
            r_min_index <= '0;
        end else if (w_accept) begin
            if ((r_count == 3'd0) || w_cand_lt) begin
                r_run_min <= in_cost;
                r_run_idx <= r_count;
            end
            if (w_complete) begin
                if (w_cand_lt) begin
                    r_min_value <= in_cost;
                    r_min_index <= LAST_SLOT;
                end else begin
                    r_min_value <= r_run_min;
                    r_min_index <= r_run_idx;
                end
            end
        end
    end

    assign min_value = r_min_value;
    assign min_index = r_min_index;
`endif

endmodule

// File: tb/tb_cost_packer_8.sv
// Bench for cost_packer_8: queue-based reference model compared every cycle, plus directed literal checks.
module tb_cost_packer_8;
    localparam int W = 7;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           in_valid = 1'b0;
    logic           in_last = 1'b0;
    logic           out_ready = 1'b0;
    logic [W-1:0]   in_cost = '0;
    logic           in_ready;
    logic           out_valid;
    logic [8*W-1:0] out_data;
    logic           sync_err;
`ifdef COST_PACKER_RUNNING_MIN_EN
    logic [W-1:0]   min_value;
    logic [2:0]     min_index;
`endif

    cost_packer_8 #(.WIDTH(W), .N(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_cost   (in_cost),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .sync_err  (sync_err)
`ifdef COST_PACKER_RUNNING_MIN_EN
        ,
        .min_value (min_value),
        .min_index (min_index)
`endif
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, got, exp);
        end
    endtask

    // Reference model: pending beats in a queue, a group is emitted when 8 have arrived.
    logic [W-1:0]   m_pend[$];
    logic [W-1:0]   sent[$];
    bit             m_init = 1'b0;
    bit             sb_en = 1'b0;
    bit             rnd_en = 1'b0;
    logic           m_valid = 1'b0;
    logic [8*W-1:0] m_data = '0;
    logic           m_err = 1'b0;
    logic [W-1:0]   m_minv = '0;
    logic [2:0]     m_mini = '0;

    always @(negedge clk) begin : model
        bit             m_ready;
        bit             acc;
        bit             drain;
        logic [8*W-1:0] e;
        m_ready = !(m_pend.size() == 7 && m_valid && !out_ready);
        if (m_init) begin
            chk("in_ready", in_ready, m_ready);
            chk("out_valid", out_valid, m_valid);
            chk("out_data", out_data, m_data);
            chk("sync_err", sync_err, m_err);
`ifdef COST_PACKER_RUNNING_MIN_EN
            chk("min_value", min_value, m_minv);
            chk("min_index", min_index, m_mini);
`endif
        end
        if (sb_en && out_valid && out_ready) begin
            if (sent.size() < 8) begin
                chk("sb_underflow", 64'(sent.size()), 64'd8);
            end else begin
                e = '0;
                for (int k = 0; k < 8; k++) e[k*W +: W] = sent.pop_front();
                chk("sb_group", out_data, e);
            end
        end
        if (rst) begin
            m_pend.delete();
            m_valid = 1'b0;
            m_data  = '0;
            m_err   = 1'b0;
            m_minv  = '0;
            m_mini  = '0;
            m_init  = 1'b1;
        end else if (m_init) begin
            acc   = in_valid && m_ready;
            drain = m_valid && out_ready;
            if (drain) m_valid = 1'b0;
            if (acc) begin
                if (in_last != (m_pend.size() == 7)) m_err = 1'b1;
                m_pend.push_back(in_cost);
                if (m_pend.size() == 8) begin
                    m_minv = m_pend[0];
                    m_mini = 3'd0;
                    for (int k = 0; k < 8; k++) begin
                        m_data[k*W +: W] = m_pend[k];
                        if (m_pend[k] < m_minv) begin
                            m_minv = m_pend[k];
                            m_mini = 3'(k);
                        end
                    end
                    m_valid = 1'b1;
                    m_pend.delete();
                end
            end
        end
    end

    always @(posedge clk) begin
        if (rnd_en) begin
            #1;
            out_ready = 1'($urandom_range(0, 1));
        end
    end

    // All stimulus tasks enter and leave 1 time unit after a rising edge.
    task automatic beat(input logic [W-1:0] c, input logic last);
        bit ok;
        ok = 1'b0;
        in_valid = 1'b1;
        in_cost  = c;
        in_last  = last;
        for (int i = 0; i < 1000 && !ok; i++) begin
            @(negedge clk);
            ok = in_ready;
            @(posedge clk);
            #1;
        end
        if (!ok) chk("beat_accept_timeout", 64'(ok), 64'd1);
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_cost  = W'($urandom_range(0, 127));
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic to_neg();
        @(negedge clk);
    endtask

    task automatic to_pos();
        @(posedge clk);
        #1;
    endtask

    logic [W-1:0]   c;
    logic [W-1:0]   g1[8] = '{7'd13, 7'd5, 7'd19, 7'd100, 7'd0, 7'd1, 7'd1, 7'd127};
    logic [W-1:0]   g3[8] = '{7'd127, 7'd55, 7'd8, 7'd100, 7'd99, 7'd12, 7'd100, 7'd3};
    time            t0;

    initial begin
        fork
            begin
                #2_000_000;
                $display("FAIL watchdog: simulation did not finish in time");
                $fatal(1, "watchdog");
            end
        join_none

        rst = 1'b1;
        repeat (2) to_pos();
        rst = 1'b0;
        to_neg();
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_data", out_data, 0);
        chk("rst_sync_err", sync_err, 0);
        to_pos();

        // Costs 1..8, downstream always ready.
        out_ready = 1'b1;
        for (int i = 1; i <= 8; i++) beat(W'(i), i == 8);
        idle(0);
        to_neg();
        chk("t1_valid", out_valid, 1);
        chk("t1_data", out_data, {7'd8, 7'd7, 7'd6, 7'd5, 7'd4, 7'd3, 7'd2, 7'd1});
        chk("t1_err", sync_err, 0);
`ifdef COST_PACKER_RUNNING_MIN_EN
        chk("t1_minv", min_value, 1);
        chk("t1_mini", min_index, 0);
`endif
        to_pos();
        idle(2);

        // Two back-to-back groups, 16 beats in 16 cycles.
        t0 = $time;
        for (int i = 0; i < 16; i++) begin
            beat(i < 8 ? g1[i] : 7'd100, (i % 8) == 7);
            if (i == 7) begin
                fork
                    begin
                        @(negedge clk);
                        chk("t2_g1", out_data, {7'd127, 7'd1, 7'd1, 7'd0, 7'd100, 7'd19, 7'd5, 7'd13});
`ifdef COST_PACKER_RUNNING_MIN_EN
                        chk("t2_g1_minv", min_value, 0);
                        chk("t2_g1_mini", min_index, 4);
`endif
                    end
                join_none
            end
        end
        chk("t2_cycles", 64'(($time - t0) / 10), 64'd16);
        idle(0);
        to_neg();
        chk("t2_g2", out_data, {8{7'd100}});
`ifdef COST_PACKER_RUNNING_MIN_EN
        chk("t2_g2_minv", min_value, 100);
        chk("t2_g2_mini", min_index, 0);
`endif
        to_pos();
        idle(2);

        // Completion blocked while the previous group is held.
        out_ready = 1'b0;
        for (int i = 1; i <= 8; i++) beat(W'(i), i == 8);
        for (int i = 0; i < 7; i++) beat(g3[i], 1'b0);
        in_valid = 1'b1;
        in_cost  = g3[7];
        in_last  = 1'b1;
        repeat (3) begin
            to_neg();
            chk("t3_ready_low", in_ready, 0);
            chk("t3_hold", out_data, {7'd8, 7'd7, 7'd6, 7'd5, 7'd4, 7'd3, 7'd2, 7'd1});
            to_pos();
        end
        out_ready = 1'b1;
        to_neg();
        chk("t3_ready_release", in_ready, 1);
        to_pos();
        in_valid  = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b0;
        to_neg();
        chk("t3_valid", out_valid, 1);
        chk("t3_data", out_data, {7'd3, 7'd100, 7'd12, 7'd99, 7'd100, 7'd8, 7'd55, 7'd127});
`ifdef COST_PACKER_RUNNING_MIN_EN
        chk("t3_minv", min_value, 3);
        chk("t3_mini", min_index, 7);
`endif
        to_pos();
        out_ready = 1'b1;
        idle(2);

        // Reset in the middle of a group.
        for (int i = 1; i <= 5; i++) beat(W'(i + 20), 1'b0);
        idle(0);
        rst = 1'b1;
        to_pos();
        rst = 1'b0;
        to_neg();
        chk("t4_valid", out_valid, 0);
        chk("t4_ready", in_ready, 1);
        to_pos();
        for (int i = 9; i <= 16; i++) beat(W'(i), i == 16);
        idle(0);
        to_neg();
        chk("t4_data", out_data, {7'd16, 7'd15, 7'd14, 7'd13, 7'd12, 7'd11, 7'd10, 7'd9});
        chk("t4_err", sync_err, 0);
        to_pos();
        idle(2);

        // Early in_last: sticky framing error, group still emitted.
        for (int i = 1; i <= 8; i++) begin
            beat(W'(i + 40), i == 4);
            if (i == 4) begin
                idle(0);
                to_neg();
                chk("t5_err_set", sync_err, 1);
                to_pos();
            end
        end
        idle(0);
        to_neg();
        chk("t5_valid", out_valid, 1);
        chk("t5_data", out_data, {7'd48, 7'd47, 7'd46, 7'd45, 7'd44, 7'd43, 7'd42, 7'd41});
        to_pos();
        idle(3);
        to_neg();
        chk("t5_err_held", sync_err, 1);
        to_pos();
        rst = 1'b1;
        to_pos();
        rst = 1'b0;
        to_neg();
        chk("t5_err_cleared", sync_err, 0);
        to_pos();

        // Random throttling on both sides, 1000 groups.
        sent.delete();
        sb_en  = 1'b1;
        rnd_en = 1'b1;
        for (int g = 0; g < 1000; g++) begin
            for (int k = 0; k < 8; k++) begin
                c = W'($urandom_range(0, 127));
                sent.push_back(c);
                if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
                beat(c, k == 7);
            end
        end
        idle(0);
        rnd_en = 1'b0;
        @(posedge clk);
        #2;
        out_ready = 1'b1;
        repeat (5) to_pos();
        chk("t6_all_drained", 64'(sent.size()), 64'd0);
        sb_en = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
